// File: rtl/umi_xbar_pkg.sv
// Shared definitions for the UMI crossbar arbiters: mode encodings, the
// arbiter lock state, and helpers for one-hot decode and rotated
// find-first-set.
package umi_xbar_pkg;

  localparam logic [1:0] XBAR_MODE_PRIO = 2'b00;
  localparam logic [1:0] XBAR_MODE_RR   = 2'b10;

  // Helpers work on a fixed maximum width; callers slice off their N bits.
  localparam int XBAR_MAXN = 32;
  localparam int XBAR_IDXW = 5;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // One-hot decode of idx within an n-bit field.
  function automatic logic [XBAR_MAXN-1:0] onehot(input int idx, input int n);
    logic [XBAR_MAXN-1:0] res;
    res = '0;
    if (idx >= 0 && idx < n) res[idx[XBAR_IDXW-1:0]] = 1'b1;
    return res;
  endfunction

  // Rotate vec right by ptr, take the first set bit, rotate back. Done as a
  // wrapped scan starting at ptr, which yields the same one-hot result.
  function automatic logic [XBAR_MAXN-1:0] ffs_rot(input logic [XBAR_MAXN-1:0] vec,
                                                   input int ptr, input int n);
    logic [XBAR_MAXN-1:0] res;
    logic                 found;
    int                   j;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < XBAR_MAXN; i++) begin
      if (i < n && !found) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (vec[j[XBAR_IDXW-1:0]]) begin
          res[j[XBAR_IDXW-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/umi_arb_rotate.sv
// Combinational rotated find-first-set: grants the first requester at or
// above i_ptr, wrapping from N-1 back to 0. ptr=0 gives plain fixed priority.
module umi_arb_rotate
  import umi_xbar_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [XBAR_MAXN-1:0] w_vec;
  logic [XBAR_MAXN-1:0] w_res;
  logic                 w_unused;

  // Widen the request vector, scan it, and narrow the result back to N bits.
  always_comb begin
    w_vec        = '0;
    w_vec[N-1:0] = i_req;
    w_res        = ffs_rot(w_vec, int'(i_ptr), N);
    o_grant      = w_res[N-1:0];
  end

  assign w_unused = ^w_res[XBAR_MAXN-1:N];

endmodule

// File: rtl/umi_xbar_arbiter.sv
// Per-output-port arbiter for the UMI crossbar. Picks one of N requesters
// with fixed priority (plus starvation aging) or round-robin, and pins the
// grant to one input from the first beat of a message until its EOM beat.
module umi_xbar_arbiter
  import umi_xbar_pkg::*;
#(
  parameter int N      = 4,
  parameter int AGEW   = 4,
  parameter int AGEMAX = 15
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [1:0]   mode,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] request,
  input  logic [N-1:0] eom,
  input  logic         out_ready,
  output logic [N-1:0] grant,
  output logic         out_valid,
  output logic         locked
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_e           r_state;
  logic [PW-1:0]        r_rrPtr;
  logic [PW-1:0]        r_lockId;
  logic                 r_lockRr;
  logic                 r_active;
  logic [AGEW-1:0]      r_age [N];

  logic [N-1:0]         w_elig;
  logic [N-1:0]         w_aged;
  logic [N-1:0]         w_prioVec;
  logic [N-1:0]         w_prioGrant;
  logic [N-1:0]         w_rrGrant;
  logic [XBAR_MAXN-1:0] w_lockOh;
  logic                 w_isLocked;
  logic                 w_isRr;
  logic                 w_xfer;
  logic [PW-1:0]        w_gIdx;
  logic [PW-1:0]        w_rrNext;
  logic                 w_gEom;
  logic                 w_unused;

  assign w_isLocked = (r_state == ARB_LOCKED);
  // While a message is open the mode captured at its first beat stays in force.
  assign w_isRr     = w_isLocked ? r_lockRr : (mode == XBAR_MODE_RR);
  assign w_elig     = request & ~mask;
  assign w_prioVec  = (|w_aged) ? w_aged : w_elig;
  assign w_lockOh   = onehot(int'(r_lockId), N);
  assign w_unused   = ^w_lockOh[XBAR_MAXN-1:N];

  // Flag eligible requesters whose wait counter has saturated.
  always_comb begin
    w_aged = '0;
    for (int i = 0; i < N; i++) begin
      w_aged[i] = w_elig[i] && (r_age[i] == AGEW'(AGEMAX));
    end
  end

  umi_arb_rotate #(.N(N)) u_prio (
    .i_req   (w_prioVec),
    .i_ptr   ({PW{1'b0}}),
    .o_grant (w_prioGrant)
  );

  umi_arb_rotate #(.N(N)) u_rr (
    .i_req   (w_elig),
    .i_ptr   (r_rrPtr),
    .o_grant (w_rrGrant)
  );

  // Zero-latency grant: pinned to the lock owner mid-message, else arbitrate.
  always_comb begin
    if (!r_active)       grant = '0;
    else if (w_isLocked) grant = w_lockOh[N-1:0] & request;
    else if (w_isRr)     grant = w_rrGrant;
    else                 grant = w_prioGrant;
  end

  assign out_valid = |(grant & request);
  assign locked    = w_isLocked;
  assign w_xfer    = out_valid & out_ready;

  // Encode the one-hot grant into the index of the transferring input.
  always_comb begin
    w_gIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) w_gIdx = PW'(i);
    end
  end

  assign w_gEom   = eom[w_gIdx];
  assign w_rrNext = (w_gIdx == PW'(N - 1)) ? '0 : w_gIdx + PW'(1);

  // Lock state machine: open a message on a non-EOM beat, close it on EOM.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= ARB_OPEN;
      r_lockId <= '0;
      r_lockRr <= 1'b0;
      r_rrPtr  <= '0;
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_xfer) begin
        if (!w_gEom) begin
          r_state  <= ARB_LOCKED;
          r_lockId <= w_gIdx;
          r_lockRr <= w_isRr;
        end else begin
          r_state <= ARB_OPEN;
          if (w_isRr) r_rrPtr <= w_rrNext;
        end
      end
    end
  end

  // Starvation counters: count waiting cycles in priority mode only.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < N; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!r_active || w_isRr || !w_elig[i] || grant[i]) begin
          r_age[i] <= '0;
        end else if (r_age[i] != AGEW'(AGEMAX)) begin
          r_age[i] <= r_age[i] + AGEW'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_grantOneHot : assert property (@(posedge clk) disable iff (!nreset)
    $onehot0(grant));
  a_grantRequested : assert property (@(posedge clk) disable iff (!nreset)
    ((grant & ~request) == '0));
  a_grantLockOwner : assert property (@(posedge clk) disable iff (!nreset)
    w_isLocked |-> ((grant & ~w_lockOh[N-1:0]) == '0));
`endif

endmodule

// File: tb/tb_umi_xbar_arbiter.sv
// Self-checking bench for umi_xbar_arbiter: directed scenarios with literal
// expectations plus a long randomized run, all compared every cycle against
// a behavioural model of the arbitration rules.
module tb_umi_xbar_arbiter;

  localparam int N      = 4;
  localparam int AGEMAX = 15;

  logic         clk       = 1'b0;
  logic         nreset    = 1'b1;
  logic [1:0]   mode      = 2'b00;
  logic [N-1:0] mask      = '0;
  logic [N-1:0] request   = '0;
  logic [N-1:0] eom       = '0;
  logic         out_ready = 1'b0;
  logic [N-1:0] grant;
  logic         out_valid;
  logic         locked;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit           mActive  = 1'b0;
  bit           mLocked  = 1'b0;
  bit           mLockRr  = 1'b0;
  int           mLockId  = 0;
  int           mRr      = 0;
  int           mAge [N] = '{default: 0};
  logic [N-1:0] lastXfer = '0;

  // Message-interleave tracker driven from observed output transfers
  bit tbInMsg  = 1'b0;
  int tbMsgId  = 0;

  umi_xbar_arbiter #(.N(N), .AGEW(4), .AGEMAX(AGEMAX)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .mode      (mode),
    .mask      (mask),
    .request   (request),
    .eom       (eom),
    .out_ready (out_ready),
    .grant     (grant),
    .out_valid (out_valid),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] bitOf(input int i);
    return N'(1) << i;
  endfunction

  function automatic int idxOf(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (|(v & bitOf(i))) return i;
    return 0;
  endfunction

  function automatic bit modelIsRr();
    return mLocked ? mLockRr : (mode == 2'b10);
  endfunction

  // Expected grant from the arbitration rules and the model state.
  function automatic logic [N-1:0] modelGrant();
    logic [N-1:0] e;
    int           idx;
    if (!mActive) return '0;
    if (mLocked) return request & bitOf(mLockId);
    e = request & ~mask;
    if (mode == 2'b10) begin
      for (int k = 0; k < N; k++) begin
        idx = (mRr + k) % N;
        if (|(e & bitOf(idx))) return bitOf(idx);
      end
      return '0;
    end
    for (int i = 0; i < N; i++) if (|(e & bitOf(i)) && mAge[i] >= AGEMAX) return bitOf(i);
    for (int i = 0; i < N; i++) if (|(e & bitOf(i))) return bitOf(i);
    return '0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] eomV, input logic rdy);
    request   = req;
    eom       = eomV;
    out_ready = rdy;
  endtask

  // Advance the model on each clock edge, or clear it on reset.
  always @(posedge clk or negedge nreset) begin : modelProc
    logic [N-1:0] g;
    logic [N-1:0] e;
    bit           rr;
    int           gi;
    if (!nreset) begin
      mActive  = 1'b0;
      mLocked  = 1'b0;
      mLockRr  = 1'b0;
      mLockId  = 0;
      mRr      = 0;
      lastXfer = '0;
      for (int i = 0; i < N; i++) mAge[i] = 0;
    end else begin
      g  = modelGrant();
      e  = request & ~mask;
      rr = modelIsRr();
      lastXfer = (g != '0 && out_ready) ? g : '0;
      if (g != '0 && out_ready) begin
        gi = idxOf(g);
        if (!(|(eom & bitOf(gi)))) begin
          if (!mLocked) mLockRr = rr;
          mLocked = 1'b1;
          mLockId = gi;
        end else begin
          mLocked = 1'b0;
          if (rr) mRr = (gi + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!mActive || rr || !(|(e & bitOf(i))) || |(g & bitOf(i))) mAge[i] = 0;
        else if (mAge[i] < AGEMAX) mAge[i] = mAge[i] + 1;
      end
      mActive = 1'b1;
    end
  end

  // Compare the DUT against the model mid-cycle, every cycle.
  always @(negedge clk) begin : cmpProc
    logic [N-1:0] exp;
    int           gi;
    exp = modelGrant();
    checkOutput("grant", grant, exp);
    checkOutput("out_valid", out_valid, |exp);
    checkOutput("locked", locked, mLocked);
    if (!nreset) begin
      tbInMsg = 1'b0;
    end else if (out_valid && out_ready) begin
      gi = idxOf(grant);
      if (tbInMsg) checkOutput("no_interleave", gi, tbMsgId);
      tbInMsg = !(|(eom & bitOf(gi)));
      tbMsgId = gi;
    end
  end

  task automatic doReset();
    @(posedge clk);
    #1;
    nreset = 1'b0;
    mode   = 2'b00;
    mask   = '0;
    applyStimulus('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]   md;
    logic [N-1:0] req;
    logic [N-1:0] eomV;
    logic         rdy;
    logic [N-1:0] expGrant;
    logic         expLocked;
  } row_t;

  task automatic runRows(input string tag, input row_t rows[$]);
    foreach (rows[k]) begin
      mode = rows[k].md;
      applyStimulus(rows[k].req, rows[k].eomV, rows[k].rdy);
      @(negedge clk);
      checkOutput($sformatf("%s_grant_%0d", tag, k), grant, rows[k].expGrant);
      checkOutput($sformatf("%s_locked_%0d", tag, k), locked, rows[k].expLocked);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stimProc
    logic [N-1:0] rrExp [6];
    int           cnt [N];
    row_t         lockRows[$];
    row_t         modeRows[$];

    // Reset held for 3 cycles with every input requesting
    #1 nreset = 1'b0;
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_grant", grant, 4'b0000);
    checkOutput("reset_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 nreset = 1'b1;
    @(negedge clk);
    checkOutput("release_cycle0", grant, 4'b0000);
    @(negedge clk);
    checkOutput("release_cycle1", grant, 4'b0001);

    // Round-robin over inputs 0, 1 and 3
    doReset();
    mode = 2'b10;
    applyStimulus(4'b1011, 4'b1111, 1'b1);
    rrExp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_%0d", k), grant, rrExp[k]);
      for (int i = 0; i < N; i++) if (grant[i]) cnt[i]++;
    end
    checkOutput("rr_share0", cnt[0], 2);
    checkOutput("rr_share1", cnt[1], 2);
    checkOutput("rr_share3", cnt[3], 2);

    // Three-beat message from input 2 with a bubble and a stall
    doReset();
    lockRows = '{
      '{2'b10, 4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b0},
      '{2'b10, 4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b0},
      '{2'b10, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b1},
      '{2'b10, 4'b0101, 4'b0001, 1'b0, 4'b0100, 1'b1},
      '{2'b10, 4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1},
      '{2'b10, 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1},
      '{2'b10, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0}
    };
    runRows("lock", lockRows);

    // Starvation: input 1 promoted after 15 waiting cycles
    doReset();
    applyStimulus(4'b0011, 4'b0011, 1'b1);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      checkOutput($sformatf("starve_%0d", c), grant,
                  (c == 15 || c == 31) ? 4'b0010 : 4'b0001);
    end

    // Masked input 0 loses to input 1
    doReset();
    mask = 4'b0001;
    applyStimulus(4'b0011, 4'b0011, 1'b1);
    @(negedge clk);
    checkOutput("mask_grant", grant, 4'b0010);
    @(posedge clk);
    #1 mask = '0;

    // Mode switch mid-message only applies after the EOM beat
    doReset();
    modeRows = '{
      '{2'b00, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0},
      '{2'b10, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1},
      '{2'b10, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1},
      '{2'b10, 4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b0},
      '{2'b10, 4'b1010, 4'b1010, 1'b1, 4'b1000, 1'b0}
    };
    runRows("mode", modeRows);

    // Randomized traffic with backpressure, mode/mask changes and a reset
    doReset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 400 == 0) mode = 2'($urandom_range(0, 3));
      if (cyc % 1000 == 500) mask = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++) begin
        if (!(request[i] && !lastXfer[i])) begin
          request[i] = ($urandom_range(0, 99) < 55);
          eom[i]     = ($urandom_range(0, 2) == 0);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (cyc == 5000) nreset = 1'b0;
      if (cyc == 5002) nreset = 1'b1;
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
